// File: rtl/md5_cand_gen_pkg.sv
// md5_search_pkg: shared constants and types for the MD5 password-search datapath.
// Ports: none (package). Provides DIGITS, ASCII_ZERO, LANES_DEFAULT, ZERO_CAND and the FSM state enum.
package md5_search_pkg;
    localparam int DIGITS = 8;
    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam int LANES_DEFAULT = 3;
    localparam logic [63:0] ZERO_CAND = {DIGITS{ASCII_ZERO}};
    typedef enum logic {S_IDLE, S_RUN} state_t;
endpackage

// File: rtl/md5_cand_gen_if.sv
// md5_cand_gen_if: control and candidate-beat bundle between the search FSM, the generator and the md5 core array.
// Ports (signals): start/stop/start_val control, out_ready/out_valid handshake, out_cand/out_lane_mask beat payload,
// busy/done/beat_count status. master = generator side, slave = consumer/controller side.
interface md5_cand_gen_if #(
    parameter int LANES = md5_search_pkg::LANES_DEFAULT
);
    logic start;
    logic stop;
    logic [63:0] start_val;
    logic out_ready;
    logic out_valid;
    logic [64*LANES-1:0] out_cand;
    logic [LANES-1:0] out_lane_mask;
    logic busy;
    logic done;
    logic [31:0] beat_count;
    modport master (
        input start, stop, start_val, out_ready,
        output out_valid, out_cand, out_lane_mask, busy, done, beat_count
    );
    modport slave (
        output start, stop, start_val, out_ready,
        input out_valid, out_cand, out_lane_mask, busy, done, beat_count
    );
endinterface

// File: rtl/md5_cand_gen_bcd_ascii_add.sv
// bcd_ascii_add: combinational add of a small constant (0..9) to an 8-digit ASCII decimal value.
// Ports: a (64-bit ASCII, MSB byte = leftmost digit), inc (4-bit constant), sum (64-bit ASCII), carry_out (top-digit carry).
module bcd_ascii_add
    import md5_search_pkg::*;
(
    input  logic [63:0] a,
    input  logic [3:0]  inc,
    output logic [63:0] sum,
    output logic        carry_out
);
    logic [DIGITS:0] c;
    assign c[0] = 1'b0;
    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        logic [4:0] s;
        logic unused_hi;
        // Only the rightmost digit sees the constant; higher digits see at most a single carry.
        assign s = {1'b0, a[8*i +: 4]} + (i == 0 ? {1'b0, inc} : 5'd0) + {4'd0, c[i]};
        assign c[i+1] = s >= 5'd10;
        // Subtracting 10 in 4 bits is exact modulo 16, so the low nibble of s is enough.
        assign sum[8*i +: 8] = {ASCII_ZERO[7:4], c[i+1] ? s[3:0] - 4'd10 : s[3:0]};
        assign unused_hi = ^a[8*i+4 +: 4];
    end
    assign carry_out = c[DIGITS];
endmodule

// File: rtl/md5_cand.sv
// md5_cand_gen: issues LANES ascending 8-digit ASCII password candidates per beat with valid/ready, stop and done.
// Ports: clk, reset_n (async active-low), bus (md5_cand_gen_if.master: start/stop/start_val in,
// out_ready in, out_valid/out_cand/out_lane_mask/busy/done/beat_count out).
module md5_cand_gen
    import md5_search_pkg::*;
#(
    parameter int LANES = LANES_DEFAULT
) (
    input logic clk,
    input logic reset_n,
    md5_cand_gen_if.master bus
);
    localparam logic [3:0] STEP = 4'(LANES);
    state_t state;
    logic [64*LANES-1:0] cand;
    logic [64*LANES-1:0] start_sum;
    logic [64*LANES-1:0] step_sum;
    logic [LANES-1:0] ovf;
    logic [LANES-1:0] start_cy;
    logic [LANES-1:0] step_cy;
    logic acc;
    logic exhaust;
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        bcd_ascii_add u_start (
            .a(bus.start_val), .inc(4'(k)),
            .sum(start_sum[64*k +: 64]), .carry_out(start_cy[k])
        );
        bcd_ascii_add u_step (
            .a(cand[64*k +: 64]), .inc(STEP),
            .sum(step_sum[64*k +: 64]), .carry_out(step_cy[k])
        );
    end
    assign acc = bus.out_valid && bus.out_ready;
    assign exhaust = &(ovf | step_cy);
    assign bus.out_valid = state == S_RUN;
    assign bus.busy = state == S_RUN;
    assign bus.out_cand = cand;
    assign bus.out_lane_mask = ~ovf;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            cand <= {LANES{ZERO_CAND}};
            ovf <= '1;
            bus.done <= 1'b0;
            bus.beat_count <= '0;
        end else begin
            bus.done <= 1'b0;
            if (state == S_IDLE) begin
                if (bus.start && !bus.stop) begin
                    cand <= start_sum;
                    ovf <= start_cy;
                    bus.beat_count <= '0;
                    // A malformed start_val that overflows every lane must not present an all-masked beat.
                    state <= &start_cy ? S_IDLE : S_RUN;
                    bus.done <= &start_cy;
                end
            end else begin
                if (acc) begin
                    cand <= step_sum;
                    ovf <= ovf | step_cy;
                    bus.beat_count <= bus.beat_count + 32'(bus.beat_count != '1);
                end
                if (bus.stop || (acc && exhaust)) state <= S_IDLE;
                bus.done <= !bus.stop && acc && exhaust;
            end
        end
    end
endmodule

// File: tb/tb_md5_cand_gen.sv
// tb_md5_cand_gen: directed and randomized checks of md5_cand_gen against an integer-level reference model.
module tb_md5_cand_gen;
    localparam int L = 3;
    localparam longint SPACE = 100000000;
    localparam logic [63:0] ZERO = 64'h3030303030303030;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int checks = 0;
    int failures = 0;
    bit m_reset = 1'b1;
    bit m_active = 1'b0;
    bit m_done = 1'b0;
    longint m_start = 0;
    longint m_beats = 0;
    longint m_count = 0;
    logic [64*L-1:0] hold;
    md5_cand_gen_if #(.LANES(L)) bus ();
    md5_cand_gen #(.LANES(L)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask
    function automatic logic [63:0] n2a(input longint n);
        logic [63:0] r;
        longint v;
        v = n % SPACE;
        for (int i = 0; i < 8; i++) begin
            r[8*i +: 8] = 8'h30 + 8'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction
    function automatic longint a2n(input logic [63:0] v);
        longint n;
        n = 0;
        for (int i = 7; i >= 0; i--) n = n * 10 + longint'(v[8*i +: 8] - 8'h30);
        return n;
    endfunction
    function automatic logic [63:0] lane(input int k);
        return bus.out_cand[64*k +: 64];
    endfunction
    // Reference model: lane k of beat b holds start+k+b*L; it is in range while below 10^8.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_reset = 1'b1;
            m_active = 1'b0;
            m_done = 1'b0;
            m_count = 0;
        end else begin
            m_done = 1'b0;
            if (!m_active) begin
                if (bus.start && !bus.stop) begin
                    m_start = a2n(bus.start_val);
                    m_beats = 0;
                    m_count = 0;
                    m_active = 1'b1;
                    m_reset = 1'b0;
                end
            end else begin
                if (bus.out_ready) begin
                    m_beats++;
                    if (m_count < 64'hFFFF_FFFF) m_count++;
                end
                if (bus.stop) m_active = 1'b0;
                else if (bus.out_ready && m_start + m_beats * L >= SPACE) begin
                    m_active = 1'b0;
                    m_done = 1'b1;
                end
            end
        end
    end
    always @(negedge clk) begin
        if (reset_n) begin
            logic [L-1:0] em;
            chk("out_valid", 64'(bus.out_valid), 64'(m_active));
            chk("busy", 64'(bus.busy), 64'(m_active));
            chk("done", 64'(bus.done), 64'(m_done));
            chk("beat_count", 64'(bus.beat_count), 64'(m_count));
            for (int k = 0; k < L; k++) begin
                em[k] = !m_reset && (m_start + k + m_beats * L < SPACE);
                chk($sformatf("cand%0d", k), lane(k), m_reset ? ZERO : n2a(m_start + k + m_beats * L));
            end
            chk("lane_mask", 64'(bus.out_lane_mask), 64'(em));
        end
    end
    initial begin
        #2000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end
    initial begin
        bus.start = 1'b0;
        bus.stop = 1'b0;
        bus.start_val = ZERO;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_count", 64'(bus.beat_count), 64'd0);
        chk("rst_lane0", lane(0), ZERO);
        chk("rst_lane2", lane(2), ZERO);
        chk("rst_mask", 64'(bus.out_lane_mask), 64'd0);
        bus.start_val = "00000000";
        bus.start = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("b0_lane0", lane(0), "00000000");
        chk("b0_lane1", lane(1), "00000001");
        chk("b0_lane2", lane(2), "00000002");
        chk("b0_mask", 64'(bus.out_lane_mask), 64'b111);
        @(negedge clk);
        chk("b1_lane0", lane(0), "00000003");
        chk("b1_lane1", lane(1), "00000004");
        chk("b1_lane2", lane(2), "00000005");
        repeat (2) @(negedge clk);
        chk("b3_lane0", lane(0), "00000009");
        chk("b3_lane1", lane(1), "00000010");
        chk("b3_count", 64'(bus.beat_count), 64'd3);
        bus.out_ready = 1'b0;
        hold = bus.out_cand;
        repeat (5) begin
            @(negedge clk);
            for (int k = 0; k < L; k++) chk("bp_hold", lane(k), hold[64*k +: 64]);
            chk("bp_count", 64'(bus.beat_count), 64'd3);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("b4_lane0", lane(0), "00000012");
        chk("b4_count", 64'(bus.beat_count), 64'd4);
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        chk("stop_valid", 64'(bus.out_valid), 64'd0);
        chk("stop_count", 64'(bus.beat_count), 64'd5);
        chk("stop_done", 64'(bus.done), 64'd0);
        bus.out_ready = 1'b0;
        bus.start_val = "00000500";
        bus.start = 1'b1;
        @(negedge clk);
        bus.start_val = "00000700";
        chk("restart_lane0", lane(0), "00000500");
        chk("restart_lane2", lane(2), "00000502");
        @(negedge clk);
        bus.start = 1'b0;
        chk("ign_start_lane0", lane(0), "00000500");
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("ign_start_next", lane(0), "00000503");
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("arst_valid", 64'(bus.out_valid), 64'd0);
        chk("arst_busy", 64'(bus.busy), 64'd0);
        chk("arst_count", 64'(bus.beat_count), 64'd0);
        chk("arst_lane1", lane(1), ZERO);
        chk("arst_mask", 64'(bus.out_lane_mask), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("arst_done", 64'(bus.done), 64'd0);
        bus.start_val = "00000000";
        bus.start = 1'b1;
        bus.stop = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.stop = 1'b0;
        chk("start_stop_idle", 64'(bus.out_valid), 64'd0);
        bus.out_ready = 1'b0;
        bus.start_val = "99999998";
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("ex8_lane0", lane(0), "99999998");
        chk("ex8_lane1", lane(1), "99999999");
        chk("ex8_mask", 64'(bus.out_lane_mask), 64'b011);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("ex8_done", 64'(bus.done), 64'd1);
        chk("ex8_busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        chk("ex8_done_pulse", 64'(bus.done), 64'd0);
        bus.start_val = "99999997";
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("ex7_mask", 64'(bus.out_lane_mask), 64'b111);
        chk("ex7_lane2", lane(2), "99999999");
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("ex7_done", 64'(bus.done), 64'd1);
        for (int r = 0; r < 40; r++) begin
            longint sn;
            sn = ($urandom_range(0, 1) == 1) ? SPACE - longint'($urandom_range(1, 80))
                                               : longint'($urandom_range(0, 99999999));
            bus.start_val = n2a(sn);
            bus.start = 1'b1;
            bus.stop = 1'b0;
            bus.out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            bus.start = 1'b0;
            for (int c = 0; c < 150 && m_active; c++) begin
                bus.out_ready = $urandom_range(0, 3) != 0;
                bus.stop = $urandom_range(0, 39) == 0;
                bus.start = $urandom_range(0, 15) == 0;
                bus.start_val = n2a(longint'($urandom_range(0, 99999999)));
                @(negedge clk);
            end
            bus.start = 1'b0;
            bus.out_ready = 1'b0;
            bus.stop = 1'b1;
            @(negedge clk);
            bus.stop = 1'b0;
            chk("rand_ends_idle", 64'(bus.busy), 64'd0);
            @(negedge clk);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/md5_cand_gen.md
# md5_cand_gen

Candidate generator for the MD5 password-search datapath. It produces 8-character ASCII decimal password candidates in ascending order and issues LANES of them per beat, one per parallel md5 core. It uses a valid/ready handshake, and the hash-compare logic can abort it with `stop` once a match is found. It sits between the top-level search FSM and the md5 core array, and is the source end of the candidate path that the compare logic consumes.

## Interface
- LANES, default 3: candidates per beat; legal range 1..9.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; begins a search from `start_val`; honoured only in IDLE.
- stop  in  1  abort, e.g. a match was found; honoured in RUN.
- start_val  in  64  first candidate as 8 ASCII digits; byte [63:56] is the leftmost digit.
- out_ready  in  1  downstream accepts the current beat.
- out_valid  out  1  beat valid.
- out_cand  out  64*LANES  lane k at [64k +: 64], same byte order as `start_val`.
- out_lane_mask  out  LANES  bit k=1: lane k holds an in-range candidate.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when the search space is exhausted.
- beat_count  out  32  beats accepted since the last `start`.

## Operation
- States:
  - IDLE: out_valid=0.
  - RUN: out_valid=1.
- IDLE→RUN on `start` with `stop`=0.
  - Lane k loads `start_val + k`.
  - Per-lane overflow flag ovf[k] is set if that add carried out of the top digit.
  - beat_count is cleared.
- In RUN, a beat is accepted when out_valid && out_ready. On accept:
  - Every lane adds LANES, and any carry-out sets ovf[k]. ovf is sticky until the next `start`.
  - beat_count increments, saturating at 2^32-1.
- out_lane_mask = ~ovf. An overflowed lane keeps counting (its value wraps) but is masked.
- If all ovf bits are set after an accept: go RUN→IDLE and pulse `done`. A beat with an all-zero mask is never presented.
- `stop` in RUN: go to IDLE next cycle, no `done`, and any accept in the same cycle is still counted. `stop` has priority over the exhaustion transition; `done` stays 0.
- `start` during RUN is ignored. `start`+`stop` together in IDLE: stay IDLE.
- Arithmetic:
  - Per-digit BCD on the low nibble only; the high nibble is fixed at 4'h3.
  - Digit sum ≥10 subtracts 10 and carries to the next digit.
  - The adder constant is ≤9, so at most one carry enters each digit.
- `start_val` must be 8 ASCII digits. Any other value gives unspecified candidates, but the FSM must still terminate or stop normally.
- Reset values: out_valid=0, busy=0, done=0, out_lane_mask=0, beat_count=0, all lanes 64'h3030303030303030 ("00000000"), ovf=all 1s.

## Timing
- `start` sampled at edge t: out_valid=1 and lane data valid from t+1.
- Accept at edge t: the next candidates appear at t+1. This gives a sustained throughput of one beat per cycle.
- out_cand and out_lane_mask are held stable while out_valid && !out_ready.
- `done` is high for exactly the cycle after the final accept, coincident with out_valid=0.
- `stop` at edge t: out_valid=0 from t+1.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Asynchronous reset mid-run forces all reset values immediately. No `done` is generated.

## Structure
- Shared package `md5_search_pkg`:
  - DIGITS=8.
  - ASCII_ZERO=8'h30.
  - State enum {S_IDLE, S_RUN}.
  - LANES default.
- Sub-module `bcd_ascii_add`: combinational. Takes a 64-bit ASCII value plus a 4-bit constant (0..9) and returns a 64-bit sum and a carry_out. It is instantiated 2×LANES times: LANES for the start offsets and LANES for the step.

## Test plan
- Reset, no start → out_valid=0, busy=0, beat_count=0, lanes all "00000000", mask=0.
- LANES=3, start_val "00000000", out_ready=1:
  - Beat 0 = "00000000","00000001","00000002", mask 111.
  - Beat 1 = "00000003","00000004","00000005".
  - Beat 3 lane 0 = "00000009", lane 1 = "00000010" (digit carry).
- Backpressure: out_ready=0 for 5 cycles mid-run → out_cand held bit-identical, beat_count unchanged. Releasing it resumes with no skipped or duplicated candidates.
- Exhaustion:
  - start_val "99999998" → one beat: lane 0 "99999998", lane 1 "99999999", mask 011. Accept → done pulses, busy=0.
  - start_val "99999997" → mask 111, then done.
- stop asserted on the accept cycle after 4 accepted beats → beat_count=5, out_valid=0 next cycle, done never asserted. A new `start` then restarts from the new start_val.
- reset_n low mid-run, asynchronously between edges → outputs reach reset values before the next edge. `start` ignored while busy: a second start_val has no effect.
